uio_uart_tx: RTL and testbench

//  Serial transmitter that drives one uio pin as an output. It is the outbound

---
 rtl/uio_uart_tx_if.sv | 10 +
 rtl/uio_uart_tx.sv | 154 +++++++++++++++
 tb/tb_uio_uart_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uio_uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives tx_data/tx_valid; the transmitter answers on tx_ready.
interface uio_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uio_uart_tx.sv
// Async-serial transmitter for one uio pin: start, LSB-first data,
// optional even parity, then stop bit(s). Every output is a flop.
module uio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uio_uart_tx_if.slave  bus,
    output logic          tx_out,
    output logic          tx_oe,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic        LAST_STP = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        stp_q, stp_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        tx_out_q, tx_out_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
    logic        tx_oe_q, tx_oe_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stp_d      = stp_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_out_d   = tx_out_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        tx_oe_d    = 1'b1;
        // First edge after reset release opens the pin and the handshake.
        if (!tx_oe_q) tx_ready_d = 1'b1;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (tx_ready_q && bus.tx_valid) begin
                    shreg_d    = bus.tx_data;
                    par_d      = ^bus.tx_data[DATA_BITS-1:0];
                    state_d    = START;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    tx_out_d   = 1'b0;
                    cnt_d      = CNT_MAX;
                    bit_d      = '0;
                    stp_d      = 1'b0;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d  = DATA;
                    cnt_d    = CNT_MAX;
                    tx_out_d = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (bit_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d  = PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        tx_out_d = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    state_d  = STOP;
                    cnt_d    = CNT_MAX;
                    tx_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                tx_out_d = 1'b1;
                if (cnt_q == '0) begin
                    if (stp_q == LAST_STP) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        tx_ready_d = 1'b1;
                    end else begin
                        stp_d = 1'b1;
                        cnt_d = CNT_MAX;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stp_q      <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stp_q      <= stp_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            tx_oe_q    <= tx_oe_d;
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign tx_out       = tx_out_q;
    assign tx_oe        = tx_oe_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_uio_uart_tx.sv
// Bench for uio_uart_tx: three configurations side by side, a per-cycle
// expected line waveform queued at drive time and popped while the frame runs.
module tb_uio_uart_tx;
    logic clk;
    logic rst_n;
    logic [7:0] data_r [3];
    logic       valid_r [3];
    logic       txo_w [3];
    logic       oe_w [3];
    logic       busy_w [3];
    logic       rdy_w [3];
    int n_chk  = 0;
    int n_pass = 0;

    uio_uart_tx_if bus0 ();
    uio_uart_tx_if bus1 ();
    uio_uart_tx_if bus2 ();

    assign bus0.tx_data = data_r[0];  assign bus0.tx_valid = valid_r[0];
    assign bus1.tx_data = data_r[1];  assign bus1.tx_valid = valid_r[1];
    assign bus2.tx_data = data_r[2];  assign bus2.tx_valid = valid_r[2];
    assign rdy_w[0] = bus0.tx_ready;
    assign rdy_w[1] = bus1.tx_ready;
    assign rdy_w[2] = bus2.tx_ready;

    uio_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .tx_out(txo_w[0]), .tx_oe(oe_w[0]), .busy(busy_w[0]));
    uio_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .tx_out(txo_w[1]), .tx_oe(oe_w[1]), .busy(busy_w[1]));
    uio_uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .tx_out(txo_w[2]), .tx_oe(oe_w[2]), .busy(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int cpb_of(input int d);
        return (d == 2) ? 2 : 4;
    endfunction
    function automatic int par_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction
    function automatic int stop_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input int d, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d: observed=%b expected=%b at %0t", tag, d, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects to be called at a sample point with the DUT idle and ready.
    task automatic xfer(input int d, input logic [7:0] b, input bit keep,
                        input logic [7:0] nxt, input bit pulse);
        logic exp_q [$];
        logic e;
        int   c;
        chk("ready_before_accept", d, rdy_w[d], 1'b1);
        data_r[d]  = b;
        valid_r[d] = 1'b1;
        for (int k = 0; k < cpb_of(d); k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < cpb_of(d); k++) exp_q.push_back(b[i]);
        if (par_of(d) != 0)
            for (int k = 0; k < cpb_of(d); k++) exp_q.push_back(^b);
        for (int k = 0; k < stop_of(d) * cpb_of(d); k++) exp_q.push_back(1'b1);
        step();
        data_r[d] = nxt;
        if (!keep) valid_r[d] = 1'b0;
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_line", d, txo_w[d], e);
            chk("frame_busy", d, busy_w[d], 1'b1);
            chk("frame_ready_low", d, rdy_w[d], 1'b0);
            if (pulse && c == 5) valid_r[d] = 1'b1;
            if (pulse && c == 7) valid_r[d] = 1'b0;
            c++;
            step();
        end
        chk("idle_line", d, txo_w[d], 1'b1);
        chk("idle_busy", d, busy_w[d], 1'b0);
        chk("idle_ready", d, rdy_w[d], 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            data_r[d]  = 8'h00;
            valid_r[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_line", d, txo_w[d], 1'b1);
            chk("rst_oe", d, oe_w[d], 1'b0);
            chk("rst_ready", d, rdy_w[d], 1'b0);
            chk("rst_busy", d, busy_w[d], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", 0, rdy_w[0], 1'b0);
        step();
        for (int d = 0; d < 3; d++) begin
            chk("first_edge_oe", d, oe_w[d], 1'b1);
            chk("first_edge_ready", d, rdy_w[d], 1'b1);
        end

        // 0xA5, no parity: 40-cycle frame
        xfer(0, 8'hA5, 1'b0, 8'h00, 1'b0);
        // even parity on 0x07: 44-cycle frame
        xfer(1, 8'h07, 1'b0, 8'h00, 1'b0);
        // two stop bits, 2 clocks per bit: 22-cycle frame
        xfer(2, 8'hF0, 1'b0, 8'h00, 1'b0);

        // back-to-back with valid held: one idle cycle, then the 0xFF frame
        xfer(0, 8'h00, 1'b1, 8'hFF, 1'b0);
        xfer(0, 8'hFF, 1'b0, 8'h00, 1'b0);
        step();
        chk("b2b_done_line", 0, txo_w[0], 1'b1);

        // data change after accept and valid pulse while busy are ignored
        xfer(0, 8'h81, 1'b0, 8'h3C, 1'b1);
        step();
        chk("no_queued_line", 0, txo_w[0], 1'b1);
        chk("no_queued_busy", 0, busy_w[0], 1'b0);

        // reset in the middle of a data bit of 0x55
        data_r[0]  = 8'h55;
        valid_r[0] = 1'b1;
        step();
        valid_r[0] = 1'b0;
        repeat (9) step();
        chk("pre_abort_line", 0, txo_w[0], 1'b0);
        chk("pre_abort_busy", 0, busy_w[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_line", 0, txo_w[0], 1'b1);
        chk("abort_oe", 0, oe_w[0], 1'b0);
        chk("abort_busy", 0, busy_w[0], 1'b0);
        chk("abort_ready", 0, rdy_w[0], 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk("rerelease_oe", 0, oe_w[0], 1'b1);
        chk("rerelease_ready", 0, rdy_w[0], 1'b1);
        xfer(0, 8'h12, 1'b0, 8'h00, 1'b0);
        xfer(1, 8'h12, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
